isa_capture_sequencer: RTL and testbench

- Sequences the ISA-cycle capture buffer: arming, circular pre-trigger recording, trigger detection, post-trigger counting and host readout.
- Sits between the bus-cycle sampler, which presents one 26-bit record per decoded cycle, and the dual-port capture RAM. It drives every RAM address, enable and write-data line.
- Streams the captured window oldest-first to the host interface over a valid/ready handshake.

---
 rtl/isa_capture_sequencer_if.sv | 37 +++
 rtl/isa_capture_sequencer.sv | 108 ++++++++++
 tb/tb_isa_capture_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/isa_capture_sequencer_if.sv
// isa_capture_sequencer_if: sampler, trigger setup, capture RAM and host readout signals of the capture sequencer
//   master: environment side (sampler, host, RAM) drives the sample, control, config, MemRdData and OutReady lines
//   slave:  sequencer side drives the RAM address/enable/data, the readout stream and the status lines
interface isa_capture_sequencer_if #(parameter int AW = 12, parameter int DW = 26);
  logic SampleValid;
  logic [DW-1:0] SampleData;
  logic Arm;
  logic Abort;
  logic ForceTrig;
  logic [19:0] TrigAddr;
  logic [19:0] TrigMask;
  logic [2:0] TrigType;
  logic [2:0] TrigTypeMask;
  logic [AW-1:0] PostCount;
  logic MemWrEn;
  logic [AW-1:0] MemWrAddr;
  logic [DW-1:0] MemWrData;
  logic MemRdEn;
  logic [AW-1:0] MemRdAddr;
  logic [DW-1:0] MemRdData;
  logic [DW-1:0] OutData;
  logic OutValid;
  logic OutReady;
  logic [2:0] State;
  logic Triggered;
  logic Done;
  modport master (
    output SampleValid, SampleData, Arm, Abort, ForceTrig, TrigAddr, TrigMask, TrigType, TrigTypeMask, PostCount,
    output MemRdData, OutReady,
    input MemWrEn, MemWrAddr, MemWrData, MemRdEn, MemRdAddr, OutData, OutValid, State, Triggered, Done
  );
  modport slave (
    input SampleValid, SampleData, Arm, Abort, ForceTrig, TrigAddr, TrigMask, TrigType, TrigTypeMask, PostCount,
    input MemRdData, OutReady,
    output MemWrEn, MemWrAddr, MemWrData, MemRdEn, MemRdAddr, OutData, OutValid, State, Triggered, Done
  );
endinterface

// File: rtl/isa_capture_sequencer.sv
// isa_capture_sequencer: arms, records a circular pre-trigger window, counts post-trigger records and streams the window oldest-first
//   Clock50MHz, Reset (async, active-high) plain ports; everything else on bus (slave modport):
//   sample strobe/record in, arm/abort/force and trigger config in, capture RAM write/read ports out,
//   OutData/OutValid/OutReady readout stream, State/Triggered/Done status out
module isa_capture_sequencer #(
  parameter int AW = 12,
  parameter int DW = 26
) (
  input logic Clock50MHz,
  input logic Reset,
  isa_capture_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, POST, READOUT} state_t;
  state_t state, stateNext;
  logic [AW-1:0] wrPtr, postCnt, rdAddr;
  logic [AW:0] sampleCnt, cntNext, rdLeft;
  logic [DW-1:0] outData;
  logic rdPend, outValid, triggered, done;
  logic wrEn, hit, rdIssue, accept, lastAccept, startArm, toReadout;
  // sampleCnt saturates at DEPTH, which is the only value with the top bit set
  assign cntNext = sampleCnt + {{AW{1'b0}}, ~sampleCnt[AW]};
  assign hit = bus.SampleValid & (bus.ForceTrig |
    ((((bus.SampleData[19:0] ^ bus.TrigAddr) & bus.TrigMask) == 20'd0) &
     (((bus.SampleData[22:20] ^ bus.TrigType) & bus.TrigTypeMask) == 3'd0)));
  always_ff @(posedge Clock50MHz or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= stateNext;
  always_comb begin
    stateNext = state;
    wrEn = 1'b0;
    rdIssue = 1'b0;
    accept = 1'b0;
    lastAccept = 1'b0;
    startArm = 1'b0;
    toReadout = 1'b0;
    if (bus.Abort) stateNext = IDLE;
    else if (state == IDLE) begin
      startArm = bus.Arm;
      stateNext = bus.Arm ? ARMED : IDLE;
    end else if (state == ARMED || state == POST) begin
      wrEn = bus.SampleValid;
      toReadout = (state == ARMED) ? hit & (postCnt == '0) : wrEn & (postCnt == AW'(1));
      stateNext = toReadout ? READOUT : (state == ARMED && hit) ? POST : state;
    end else begin
      accept = outValid & bus.OutReady;
      // the next read goes out in the same cycle the held record is taken
      rdIssue = (rdLeft != '0) & ~rdPend & (~outValid | bus.OutReady);
      lastAccept = accept & (rdLeft == '0) & ~rdPend;
      stateNext = lastAccept ? IDLE : READOUT;
    end
  end
  always_ff @(posedge Clock50MHz or posedge Reset)
    if (Reset) begin
      wrPtr <= '0;
      postCnt <= '0;
      rdAddr <= '0;
      sampleCnt <= '0;
      rdLeft <= '0;
      outData <= '0;
      rdPend <= 1'b0;
      outValid <= 1'b0;
      triggered <= 1'b0;
      done <= 1'b0;
    end else if (bus.Abort) begin
      outValid <= 1'b0;
      rdPend <= 1'b0;
      done <= 1'b0;
    end else begin
      if (startArm) begin
        wrPtr <= '0;
        sampleCnt <= '0;
        triggered <= 1'b0;
        done <= 1'b0;
        postCnt <= bus.PostCount;
      end
      if (wrEn) begin
        wrPtr <= wrPtr + AW'(1);
        sampleCnt <= cntNext;
        if (state == POST) postCnt <= postCnt - AW'(1);
      end
      if (state == ARMED && hit) triggered <= 1'b1;
      // oldest surviving record sits Len entries behind the post-write pointer
      if (toReadout) begin
        rdAddr <= wrPtr + AW'(1) - cntNext[AW-1:0];
        rdLeft <= cntNext;
      end
      if (rdIssue) begin
        rdAddr <= rdAddr + AW'(1);
        rdLeft <= rdLeft - (AW+1)'(1);
      end
      rdPend <= rdIssue;
      if (rdPend) begin
        outData <= bus.MemRdData;
        outValid <= 1'b1;
      end else if (accept) outValid <= 1'b0;
      if (lastAccept) done <= 1'b1;
    end
  assign bus.MemWrEn = wrEn;
  assign bus.MemWrAddr = wrPtr;
  assign bus.MemWrData = wrEn ? bus.SampleData : '0;
  assign bus.MemRdEn = rdIssue;
  assign bus.MemRdAddr = rdAddr;
  assign bus.OutData = outData;
  assign bus.OutValid = outValid;
  assign bus.State = {1'b0, state};
  assign bus.Triggered = triggered;
  assign bus.Done = done;
endmodule

// File: tb/tb_isa_capture_sequencer.sv
// tb_isa_capture_sequencer: randomized scoreboard bench for the capture sequencer with a behavioural capture RAM
module tb_isa_capture_sequencer;
  localparam int AW = 12;
  localparam int DW = 26;
  localparam int DEPTH = 1 << AW;
  logic Clock50MHz = 1'b0;
  logic Reset = 1'b1;
  isa_capture_sequencer_if #(.AW(AW), .DW(DW)) bus ();
  isa_capture_sequencer #(.AW(AW), .DW(DW)) dut (.Clock50MHz(Clock50MHz), .Reset(Reset), .bus(bus));
  always #10 Clock50MHz = ~Clock50MHz;
  logic [DW-1:0] mem [DEPTH];
  always @(posedge Clock50MHz) begin
    if (bus.MemWrEn) mem[bus.MemWrAddr] <= bus.MemWrData;
    if (bus.MemRdEn) bus.MemRdData <= mem[bus.MemRdAddr];
  end
  int checks = 0;
  int passed = 0;
  logic [DW-1:0] expQ [$];
  logic [DW-1:0] stimD [$];
  bit stimF [$];
  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endfunction
  function automatic bit ruleHit(logic [DW-1:0] d, logic [19:0] ta, logic [19:0] tm, logic [2:0] tt, logic [2:0] ttm);
    return (((d[19:0] ^ ta) & tm) == 20'd0) && (((d[22:20] ^ tt) & ttm) == 3'd0);
  endfunction
  logic stallPrev = 1'b0;
  logic [DW-1:0] dataPrev;
  always @(negedge Clock50MHz) begin
    if (Reset) stallPrev = 1'b0;
    else begin
      if (stallPrev) begin
        check("hold_valid", 32'(bus.OutValid), 32'd1);
        check("hold_data", 32'(bus.OutData), 32'(dataPrev));
      end
      if (bus.OutValid && !bus.OutReady) check("rd_during_stall", 32'(bus.MemRdEn), 32'd0);
      if (bus.OutValid && bus.OutReady) begin
        check("record_expected", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) check("out_data", 32'(bus.OutData), 32'(expQ.pop_front()));
      end
      stallPrev = bus.OutValid && !bus.OutReady && !bus.Abort;
      dataPrev = bus.OutData;
    end
  end
  task automatic tick();
    @(posedge Clock50MHz);
    #1;
  endtask
  task automatic checkZero(string tag);
    check({tag, "_state"}, 32'(bus.State), 32'd0);
    check({tag, "_trig"}, 32'(bus.Triggered), 32'd0);
    check({tag, "_done"}, 32'(bus.Done), 32'd0);
    check({tag, "_ovalid"}, 32'(bus.OutValid), 32'd0);
    check({tag, "_odata"}, 32'(bus.OutData), 32'd0);
    check({tag, "_wren"}, 32'(bus.MemWrEn), 32'd0);
    check({tag, "_wraddr"}, 32'(bus.MemWrAddr), 32'd0);
    check({tag, "_wrdata"}, 32'(bus.MemWrData), 32'd0);
    check({tag, "_rden"}, 32'(bus.MemRdEn), 32'd0);
    check({tag, "_rdaddr"}, 32'(bus.MemRdAddr), 32'd0);
  endtask
  // readyMode: 0 always ready, 1 random ready, 2 stall 20 cycles on first record, 3 abort while a record is held
  task automatic capture(string tag, logic [19:0] ta, logic [19:0] tm, logic [2:0] tt, logic [2:0] ttm,
                         logic [AW-1:0] pc, int gapPct, int readyMode);
    logic [DW-1:0] hist [$];
    bit trig = 0;
    bit fin = 0;
    int post = int'(pc);
    int cyc = 0;
    int stallLeft = 20;
    bus.TrigAddr = ta;
    bus.TrigMask = tm;
    bus.TrigType = tt;
    bus.TrigTypeMask = ttm;
    bus.PostCount = pc;
    bus.OutReady = 1'b1;
    bus.Arm = 1'b1;
    tick();
    bus.Arm = 1'b0;
    @(negedge Clock50MHz);
    check({tag, "_armed"}, 32'(bus.State), 32'd1);
    check({tag, "_armtrig"}, 32'(bus.Triggered), 32'd0);
    check({tag, "_armdone"}, 32'(bus.Done), 32'd0);
    tick();
    for (int i = 0; i < stimD.size() && !fin; i++) begin
      while ($urandom_range(99) < gapPct) begin
        bus.SampleValid = 1'b0;
        bus.ForceTrig = 1'($urandom_range(1));
        bus.SampleData = DW'($urandom);
        tick();
      end
      bus.SampleValid = 1'b1;
      bus.SampleData = stimD[i];
      bus.ForceTrig = stimF[i];
      hist.push_back(stimD[i]);
      if (!trig) begin
        trig = stimF[i] || ruleHit(stimD[i], ta, tm, tt, ttm);
        fin = trig && post == 0;
      end else begin
        post--;
        fin = post == 0;
      end
      if (fin)
        for (int j = (hist.size() > DEPTH) ? hist.size() - DEPTH : 0; j < hist.size(); j++) expQ.push_back(hist[j]);
      tick();
    end
    bus.ForceTrig = 1'b0;
    while (!bus.Done && cyc < 3 * DEPTH + 100) begin
      if (readyMode == 3) begin
        bus.OutReady = 1'b0;
        if (bus.OutValid) begin
          bus.Abort = 1'b1;
          tick();
          bus.Abort = 1'b0;
          bus.SampleValid = 1'b0;
          @(negedge Clock50MHz);
          check({tag, "_ab_state"}, 32'(bus.State), 32'd0);
          check({tag, "_ab_ovalid"}, 32'(bus.OutValid), 32'd0);
          check({tag, "_ab_done"}, 32'(bus.Done), 32'd0);
          check({tag, "_ab_trig"}, 32'(bus.Triggered), 32'd1);
          expQ.delete();
          repeat (3) tick();
          @(negedge Clock50MHz);
          check({tag, "_ab_ovalid_late"}, 32'(bus.OutValid), 32'd0);
          check({tag, "_ab_rden_late"}, 32'(bus.MemRdEn), 32'd0);
          bus.OutReady = 1'b1;
          tick();
          stimD.delete();
          stimF.delete();
          return;
        end
      end else if (readyMode == 2 && bus.OutValid && stallLeft > 0) begin
        bus.OutReady = 1'b0;
        stallLeft--;
      end else bus.OutReady = (readyMode == 1) ? 1'($urandom_range(1)) : 1'b1;
      bus.SampleValid = 1'($urandom_range(1));
      bus.SampleData = DW'($urandom);
      tick();
      cyc++;
    end
    bus.SampleValid = 1'b0;
    bus.OutReady = 1'b1;
    @(negedge Clock50MHz);
    check({tag, "_done"}, 32'(bus.Done), 32'd1);
    check({tag, "_idle"}, 32'(bus.State), 32'd0);
    check({tag, "_triggered"}, 32'(bus.Triggered), 32'd1);
    check({tag, "_left"}, 32'(expQ.size()), 32'd0);
    expQ.delete();
    stimD.delete();
    stimF.delete();
    tick();
  endtask
  task automatic randomCapture(string tag, int readyMode);
    int k = $urandom_range(15);
    int pc = $urandom_range(12);
    for (int i = 0; i <= k + pc; i++) begin
      stimD.push_back(DW'($urandom));
      stimF.push_back(i == k);
    end
    capture(tag, 20'($urandom), ($urandom_range(3) == 0) ? 20'd0 : 20'($urandom) & 20'hF0000,
            3'($urandom), 3'($urandom), AW'(pc), 30, readyMode);
  endtask
  initial begin
    bus.SampleValid = 1'b0;
    bus.SampleData = '0;
    bus.Arm = 1'b0;
    bus.Abort = 1'b0;
    bus.ForceTrig = 1'b0;
    bus.TrigAddr = '0;
    bus.TrigMask = '0;
    bus.TrigType = '0;
    bus.TrigTypeMask = '0;
    bus.PostCount = '0;
    bus.OutReady = 1'b1;
    bus.MemRdData = '0;
    repeat (2) tick();
    checkZero("reset");
    Reset = 1'b0;
    tick();
    for (int sa = 'h300; sa <= 'h309; sa++) begin
      stimD.push_back({3'd0, 3'b100, 20'(sa)});
      stimF.push_back(1'b0);
    end
    stimD.push_back({3'd0, 3'b100, 20'h003F8});
    stimF.push_back(1'b0);
    for (int sa = 'h30A; sa <= 'h30C; sa++) begin
      stimD.push_back({3'd0, 3'b100, 20'(sa)});
      stimF.push_back(1'b0);
    end
    capture("t1", 20'h003F8, 20'hFFFFF, 3'b100, 3'b100, AW'(3), 0, 0);
    bus.Abort = 1'b1;
    tick();
    bus.Abort = 1'b0;
    @(negedge Clock50MHz);
    check("idle_abort_done", 32'(bus.Done), 32'd0);
    tick();
    for (int sa = 1; sa <= DEPTH + 5; sa++) begin
      stimD.push_back({3'($urandom), 3'b000, 20'(sa)});
      stimF.push_back(1'b0);
    end
    capture("t2", 20'(DEPTH + 5), 20'hFFFFF, 3'd0, 3'd0, AW'(0), 0, 0);
    for (int i = 0; i < DEPTH + 3; i++) begin
      stimD.push_back(DW'($urandom));
      stimF.push_back(1'b0);
    end
    capture("t3", 20'd0, 20'd0, 3'd0, 3'd0, AW'(DEPTH - 1), 0, 1);
    randomCapture("t4stall", 2);
    for (int n = 0; n < 6; n++) randomCapture("t4rand", 1);
    bus.TrigAddr = 20'hABCDE;
    bus.TrigMask = 20'hFFFFF;
    bus.TrigTypeMask = 3'd0;
    bus.PostCount = AW'(2);
    bus.Arm = 1'b1;
    tick();
    bus.Arm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.SampleValid = 1'b1;
      bus.SampleData = DW'(i);
      tick();
    end
    bus.SampleData = {6'd0, 20'hABCDE};
    bus.Abort = 1'b1;
    tick();
    bus.Abort = 1'b0;
    @(negedge Clock50MHz);
    check("t5a_state", 32'(bus.State), 32'd0);
    check("t5a_ovalid", 32'(bus.OutValid), 32'd0);
    check("t5a_done", 32'(bus.Done), 32'd0);
    check("t5a_trig", 32'(bus.Triggered), 32'd0);
    check("t5a_wren", 32'(bus.MemWrEn), 32'd0);
    tick();
    bus.SampleValid = 1'b0;
    randomCapture("t5b", 3);
    randomCapture("t5clean", 0);
    bus.TrigMask = 20'd0;
    bus.TrigTypeMask = 3'd0;
    bus.PostCount = AW'(100);
    bus.Arm = 1'b1;
    tick();
    bus.Arm = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.SampleValid = 1'b1;
      bus.SampleData = DW'($urandom);
      tick();
    end
    @(negedge Clock50MHz);
    check("t6_post", 32'(bus.State), 32'd2);
    tick();
    #4 Reset = 1'b1;
    #1 checkZero("t6_async");
    tick();
    Reset = 1'b0;
    bus.SampleValid = 1'b1;
    bus.ForceTrig = 1'b1;
    repeat (2) tick();
    @(negedge Clock50MHz);
    check("t6_force_state", 32'(bus.State), 32'd0);
    check("t6_force_trig", 32'(bus.Triggered), 32'd0);
    check("t6_force_wren", 32'(bus.MemWrEn), 32'd0);
    bus.SampleValid = 1'b0;
    bus.ForceTrig = 1'b0;
    tick();
    randomCapture("t6after", 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
